// File: rtl/shift_reg_piso_param.sv
// shift_reg_piso_param: parametrised PISO shift register with bit counter, busy/done and selectable bit order.
// Define SHIFT_REG_PISO_ROTATE_EN to add the rotate input (vacated bit takes the emitted bit).
module shift_reg_piso_param #(
  parameter int   WIDTH        = 8,
  parameter int   CNT_W        = $clog2(WIDTH + 1),
  parameter logic DEFAULT_FILL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             msb_first,
  input  logic             fill_sel,
  input  logic             sin,
`ifdef SHIFT_REG_PISO_ROTATE_EN
  input  logic             rotate,
`endif
  input  logic             enable,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic [WIDTH-1:0] q
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic out_q, out_d, out_valid_q, out_valid_d, done_q, done_d;
  logic msb_q, msb_d, fill_q, fill_d, rot_q, rot_d;
  logic emit, fbit;
  assign emit = msb_q ? sr_q[WIDTH-1] : sr_q[0];
  // Rotation feeds the emitted bit back, so after WIDTH shifts the word is restored.
  assign fbit = rot_q ? emit : (fill_q ? sin : DEFAULT_FILL);
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    rem_d       = rem_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    msb_d       = msb_q;
    fill_d      = fill_q;
    rot_d       = rot_q;
    if (state_q == IDLE) begin
      if (load) begin
        state_d = SHIFT;
        sr_d    = data;
        rem_d   = CNT_W'(WIDTH);
        msb_d   = msb_first;
        fill_d  = fill_sel;
`ifdef SHIFT_REG_PISO_ROTATE_EN
        rot_d   = rotate;
`endif
      end
    end else if (enable) begin
      out_d       = emit;
      out_valid_d = 1'b1;
      sr_d        = msb_q ? {sr_q[WIDTH-2:0], fbit} : {fbit, sr_q[WIDTH-1:1]};
      rem_d       = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      rem_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      msb_q       <= 1'b0;
      fill_q      <= 1'b0;
      rot_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      rem_q       <= rem_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      msb_q       <= msb_d;
      fill_q      <= fill_d;
      rot_q       <= rot_d;
    end
  end
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
  assign remaining = rem_q;
  assign q         = sr_q;
endmodule

// File: tb/tb_shift_reg_piso_param.sv
// tb_shift_reg_piso_param: randomized and directed checks of shift_reg_piso_param against a bit-stream model.
module tb_shift_reg_piso_param;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
  logic clk = 1'b0;
  logic rst_n, load, msb_first, fill_sel, sin, enable, rotate;
  logic [W-1:0] data;
  logic out, out_valid, busy, done;
  logic [CW-1:0] remaining;
  logic [W-1:0] q;
  int checks = 0, failures = 0;
  logic m_busy, m_msb, m_fill, m_rot, m_out, m_ov, m_done;
  logic [W-1:0] m_data, m_fills;
  int m_k;

  shift_reg_piso_param dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .msb_first(msb_first),
    .fill_sel(fill_sel), .sin(sin),
`ifdef SHIFT_REG_PISO_ROTATE_EN
    .rotate(rotate),
`endif
    .enable(enable), .out(out), .out_valid(out_valid), .busy(busy), .done(done),
    .remaining(remaining), .q(q)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_busy = 0; m_msb = 0; m_fill = 0; m_rot = 0; m_out = 0; m_ov = 0; m_done = 0;
    m_data = '0; m_fills = '0; m_k = 0;
  endtask

  // Register contents after m_k shifts: surviving data bits plus the fill bits inserted so far.
  function automatic logic [W-1:0] exp_q();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      if (!m_msb) begin
        if (i < W - m_k) r[i] = m_data[i + m_k];
        else r[i] = m_fills[i - W + m_k];
      end else begin
        if (i >= m_k) r[i] = m_data[i - m_k];
        else r[i] = m_fills[m_k - 1 - i];
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_rem();
    return m_busy ? CW'(W - m_k) : CW'(0);
  endfunction

  task automatic tick(input logic ld, input logic [W-1:0] d, input logic mf, input logic fs,
                      input logic si, input logic en, input logic rt);
    logic acc, sh, e;
    load = ld; data = d; msb_first = mf; fill_sel = fs; sin = si; enable = en; rotate = rt;
    acc = !m_busy && ld;
    sh  = m_busy && en;
    @(posedge clk); #1;
    m_ov = sh;
    m_done = sh && (m_k == W - 1);
    if (sh) begin
      e = m_msb ? m_data[W - 1 - m_k] : m_data[m_k];
      m_out = e;
      m_fills[m_k] = m_rot ? e : (m_fill ? si : 1'b0);
      m_k++;
      if (m_k == W) m_busy = 0;
    end
    if (acc) begin
      m_busy = 1; m_k = 0; m_data = d; m_msb = mf; m_fill = fs; m_fills = '0;
`ifdef SHIFT_REG_PISO_ROTATE_EN
      m_rot = rt;
`else
      m_rot = 0;
`endif
    end
  endtask

  task automatic test_reset();
    load = 0; data = '0; msb_first = 0; fill_sel = 0; sin = 0; enable = 0; rotate = 0;
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out, out_valid, busy, done, remaining, q} !== '0) begin
      failures++;
      $display("FAIL reset_state: out=%b ov=%b busy=%b done=%b rem=%0d q=%h, required all 0",
               out, out_valid, busy, done, remaining, q);
    end
    rst_n = 1;
    tick(1, 8'hB7, 0, 0, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (remaining !== CW'(5)) begin
      failures++;
      $display("FAIL reset_mid_rem: remaining=%0d required 5", remaining);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (out !== 1'b0 || q !== '0 || busy !== 1'b0 || remaining !== '0) begin
      failures++;
      $display("FAIL reset_async: out=%b q=%h busy=%b rem=%0d, required 0", out, q, busy, remaining);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done: done=%b ov=%b required 0", done, out_valid);
    end
    rst_n = 1;
    model_clear();
    tick(1, 8'hA5, 0, 0, 0, 0, 0);
    for (int k = 0; k < W; k++) begin
      tick(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (out !== m_out || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL reset_reload bit%0d: out=%b ov=%b required out=%b ov=1", k, out, out_valid, m_out);
      end
    end
  endtask

  task automatic run_order(input logic mf, input logic [W-1:0] seq, input string name);
    tick(1, 8'hC1, mf, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || remaining !== CW'(8) || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_edge1: ov=%b rem=%0d busy=%b required ov=0 rem=8 busy=1", name, out_valid, remaining, busy);
    end
    for (int n = 2; n <= 9; n++) begin
      tick(0, 0, 0, 0, $urandom_range(1), 1, 0);
      checks++;
      if (out !== seq[n-2] || out_valid !== 1'b1 || done !== (n == 9) || busy !== (n != 9)
          || remaining !== CW'(9 - n)) begin
        failures++;
        $display("FAIL %s_edge%0d: out=%b ov=%b done=%b busy=%b rem=%0d required out=%b ov=1 done=%b busy=%b rem=%0d",
                 name, n, out, out_valid, done, busy, remaining, seq[n-2], n == 9, n != 9, 9 - n);
      end
    end
    tick(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0 || remaining !== '0 || q !== 8'h00) begin
      failures++;
      $display("FAIL %s_after: done=%b ov=%b rem=%0d q=%h required 0 0 0 00", name, done, out_valid, remaining, q);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] s;
    s = 8'b1100_0001;
    run_order(0, s, "lsb");
  endtask

  task automatic test_msb_first();
    logic [W-1:0] s;
    s = 8'b1000_0011;
    run_order(1, s, "msb");
  endtask

  task automatic test_fill_stall();
    logic prev_out, prev_rem_ok;
    logic [CW-1:0] prev_rem;
    tick(1, 8'h00, 0, 1, 1, 0, 0);
    for (int c = 0; c < 2 * W; c++) begin
      prev_out = out;
      prev_rem = remaining;
      tick(0, 0, 0, 0, 1, (c % 2) == 0, 0);
      prev_rem_ok = (c % 2 == 0) ? (remaining == prev_rem - CW'(1)) : (remaining == prev_rem);
      checks++;
      if (out_valid !== ((c % 2) == 0) || !prev_rem_ok || ((c % 2) == 1 && out !== prev_out)) begin
        failures++;
        $display("FAIL fill_stall c%0d: ov=%b rem=%0d (was %0d) out=%b (was %b)",
                 c, out_valid, remaining, prev_rem, out, prev_out);
      end
    end
    checks++;
    if (q !== 8'hFF || busy !== 1'b0) begin
      failures++;
      $display("FAIL fill_final: q=%h busy=%b required q=ff busy=0", q, busy);
    end
  endtask

  task automatic test_ignored();
    logic [W-1:0] got, want;
    want = 8'h3C;
    tick(1, 8'h3C, 0, 0, 0, 0, 0);
    for (int k = 0; k < W; k++) begin
      tick(k == 4, 8'hFF, 1, 1, 1, 1, 0);
      got[k] = out;
    end
    checks++;
    if (got !== want || q !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignored_load: stream=%h q=%h busy=%b required stream=3c q=00 busy=0", got, q, busy);
    end
  endtask

  task automatic test_random();
    logic ld, en;
    for (int c = 0; c < 600; c++) begin
      ld = ($urandom_range(3) == 0);
      en = ($urandom_range(9) < 7);
      tick(ld, W'($urandom), $urandom_range(1), $urandom_range(1), $urandom_range(1), en, $urandom_range(1));
      checks++;
      if (out !== m_out || out_valid !== m_ov || done !== m_done || busy !== m_busy
          || remaining !== exp_rem() || q !== exp_q()) begin
        failures++;
        $display("FAIL random c%0d: out=%b ov=%b done=%b busy=%b rem=%0d q=%h required %b %b %b %b %0d %h",
                 c, out, out_valid, done, busy, remaining, q, m_out, m_ov, m_done, m_busy, exp_rem(), exp_q());
      end
    end
  endtask

`ifdef SHIFT_REG_PISO_ROTATE_EN
  task automatic test_rotate();
    logic [W-1:0] got, want;
    want = 8'hC1;
    tick(1, 8'hC1, 0, 1, 1, 1, 1);
    for (int k = 0; k < W; k++) begin
      tick(0, 0, 0, 0, $urandom_range(1), 1, 0);
      got[k] = out;
    end
    checks++;
    if (got !== want || q !== 8'hC1 || done !== 1'b1) begin
      failures++;
      $display("FAIL rotate: stream=%h q=%h done=%b required stream=c1 q=c1 done=1", got, q, done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_fill_stall();
    test_ignored();
    test_random();
`ifdef SHIFT_REG_PISO_ROTATE_EN
    test_rotate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_reg_piso_param.md
Name: shift_reg_piso_param

Overview:
Parametrised parallel-in/serial-out shift register. It is the next generation of the team's 4-bit load-and-shift block, adding:
- configurable width
- per-transfer bit order (LSB-first or MSB-first)
- serial fill input
- a bit counter with busy/done status, so a transfer terminates cleanly after WIDTH bits

It sits between parallel datapaths and serial links or LED/test outputs in lab designs.

Parameters:
WIDTH, 8, shift register width in bits (>= 2).
CNT_W, $clog2(WIDTH+1), width of the remaining-bit counter (derived; do not override).
DEFAULT_FILL, 1'b0, value shifted into the vacated bit when fill_sel=0.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
load  input  1  parallel-load request; takes effect only in IDLE.
data  input  WIDTH  parallel word; captured on an accepted load.
msb_first  input  1  bit order for the transfer; sampled on an accepted load.
fill_sel  input  1  1 = vacated bit takes sin; 0 = takes DEFAULT_FILL; sampled on an accepted load.
sin  input  1  serial fill input.
enable  input  1  shift advance; one bit per cycle while high in SHIFT.
out  output  1  registered serial output bit.
out_valid  output  1  high for exactly the cycles in which out was updated with a new bit.
busy  output  1  high in SHIFT.
done  output  1  one-cycle pulse, coincident with out_valid of the last bit.
remaining  output  CNT_W  bits still to emit.
q  output  WIDTH  current shift register contents (observability).

Behaviour:
- All state is in one clocked process: async clear on negedge rst_n, otherwise posedge clk.
- Reset values: out=0, out_valid=0, busy=0, done=0, remaining=0, q=0. Latched mode bits are 0. State is IDLE.
- Reset may assert mid-transfer. The transfer is abandoned; no done pulse is produced.
- FSM states: IDLE, SHIFT.
- IDLE:
  - load=1 at an edge: q<=data; remaining<=WIDTH; msb_first and fill_sel are latched; state goes to SHIFT.
  - enable is ignored in IDLE, including when it arrives in the same cycle as load.
  - out holds its last value; out_valid=0.
- SHIFT, enable=1 at an edge:
  - LSB-first: out<=q[0]; q<=q>>1, with q[WIDTH-1] taking the fill bit.
  - MSB-first: out<=q[WIDTH-1]; q<=q<<1, with q[0] taking the fill bit.
  - The fill bit is sin when fill_sel=1, else DEFAULT_FILL.
  - remaining decrements by 1; out_valid<=1.
- SHIFT, enable=0: q, out and remaining hold; out_valid<=0.
- Termination: when remaining==1 and enable=1, the last bit is emitted, done<=1 for that one cycle, and state returns to IDLE. busy falls on the same edge.
- load during SHIFT is ignored: no restart and no data capture.
- Latency: the first bit appears on out after the first enabled edge that follows the load edge. With enable held high, bit k (k=0..WIDTH-1) appears on edge k+2 counted from the load edge (load edge = edge 1).
- Use non-blocking assignments only.
- remaining never underflows; it is 0 in IDLE after a completed transfer.

Optional Feature:
Macro SHIFT_REG_PISO_ROTATE_EN.
- Defined:
  - Adds input port rotate (1 bit), sampled on an accepted load.
  - When latched rotate=1, the vacated bit takes the bit just emitted (circular rotate), overriding fill_sel.
  - After WIDTH shifts, q equals the originally loaded data.
- Undefined:
  - The rotate port is absent.
  - The fill bit is always chosen by fill_sel.

Test Plan:
- Reset: assert rst_n=0 mid-transfer (remaining=5) -> out=0, q=0, busy=0, remaining=0 immediately, with no done pulse. After release, a new load works normally.
- LSB-first: WIDTH=8, load data=8'hC1, msb_first=0, enable held high -> out = 1,0,0,0,0,0,1,1 on edges 2..9. done is high only on edge 9; busy drops on edge 9; remaining counts 8..0.
- MSB-first: load 8'hC1, msb_first=1 -> out = 1,1,0,0,0,0,0,1; q after the transfer = 8'h00 (fill_sel=0, DEFAULT_FILL=0).
- Fill and stall: load 8'h00, fill_sel=1, sin=1, enable toggling 1,0,1,0... -> out_valid and remaining change only on enabled edges; out holds while enable=0; final q = 8'hFF after 8 enabled edges.
- Ignored requests: load 8'h3C, then pulse load with 8'hFF at remaining=4 -> the stream continues from 8'h3C. load+enable in the same IDLE cycle -> load accepted, no bit emitted that cycle.
- With SHIFT_REG_PISO_ROTATE_EN: load 8'hC1 with rotate=1, enable held -> same out sequence as LSB-first, and q==8'hC1 after done.
